// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a single-outstanding req/gnt/rvalid data bus.
// Handles byte-lane steering, store data replication and load sign/zero extension,
// and requests a pipeline stall until each access completes.
// Optional feature macro: MEM_LSU_MISALIGN_CHECK_EN (flag misaligned half/word accesses
// instead of truncating the address to natural alignment).
module mem_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [3:0]        mem_op_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_we_in,
  input  logic              interrupt_flush_in,
  output logic              dbus_req_out,
  output logic              dbus_we_out,
  output logic [ADDR_W-1:0] dbus_addr_out,
  output logic [3:0]        dbus_be_out,
  output logic [DATA_W-1:0] dbus_wdata_out,
  input  logic              dbus_gnt_in,
  input  logic              dbus_rvalid_in,
  input  logic [DATA_W-1:0] dbus_rdata_in,
  output logic              stall_req_out,
  output logic              load_valid_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              misalign_out
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b0110;
  localparam logic [3:0] OP_SH  = 4'b0111;
  localparam logic [3:0] OP_SW  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic       is_load, is_store_op, is_store, valid_op;
  logic       is_byte, is_half, is_word, is_signed;
  logic       misaligned, start;
  logic [1:0] a, a_eff;
  logic [3:0] be_d;
  logic [DATA_W-1:0] wdata_d;

  // Captured access attributes used to extract the load result.
  logic       cap_byte, cap_half, cap_signed;
  logic [1:0] cap_a;
  logic       discard_q;

  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [DATA_W-1:0] ext_data;

  assign a = mem_addr_in[1:0];

  // Decode access type and size from the op field.
  always_comb begin
    is_load     = 1'b0;
    is_store_op = 1'b0;
    is_byte     = 1'b0;
    is_half     = 1'b0;
    is_word     = 1'b0;
    is_signed   = 1'b0;
    case (mem_op_in)
      OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LW:   begin is_load = 1'b1; is_word = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
      OP_SB:   begin is_store_op = 1'b1; is_byte = 1'b1; end
      OP_SH:   begin is_store_op = 1'b1; is_half = 1'b1; end
      OP_SW:   begin is_store_op = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  // A store op without the write qualifier is treated as no access.
  assign is_store = is_store_op & mem_we_in;
  assign valid_op = is_load | is_store;

`ifdef MEM_LSU_MISALIGN_CHECK_EN
  assign misaligned = valid_op & ((is_half & (a == 2'b11)) | (is_word & (a != 2'b00)));
  assign a_eff      = a;
`else
  // Without the check, halves and words are forced to natural alignment.
  assign misaligned = 1'b0;
  assign a_eff      = is_word ? 2'b00 : (is_half ? {a[1], 1'b0} : a);
`endif

  assign start = valid_op & ~misaligned & ~interrupt_flush_in;

  // Byte enables and lane-replicated write data for the incoming access.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_data_in;
    if (is_byte) begin
      be_d    = 4'(4'b0001 << a_eff);
      wdata_d = DATA_W'({4{mem_data_in[7:0]}});
    end else if (is_half) begin
      be_d    = 4'(4'b0011 << a_eff);
      wdata_d = DATA_W'({2{mem_data_in[15:0]}});
    end
  end

  // Lane select and sign/zero extension of the returned read data.
  always_comb begin
    case (cap_a)
      2'd0:    sel_b = dbus_rdata_in[7:0];
      2'd1:    sel_b = dbus_rdata_in[15:8];
      2'd2:    sel_b = dbus_rdata_in[23:16];
      default: sel_b = dbus_rdata_in[31:24];
    endcase
    case (cap_a)
      2'd0:    sel_h = dbus_rdata_in[15:0];
      2'd1:    sel_h = dbus_rdata_in[23:8];
      default: sel_h = dbus_rdata_in[31:16];
    endcase
    ext_data = dbus_rdata_in;
    if (cap_byte) begin
      ext_data = DATA_W'({{24{cap_signed & sel_b[7]}}, sel_b});
    end else if (cap_half) begin
      ext_data = DATA_W'({{16{cap_signed & sel_h[15]}}, sel_h});
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (dbus_gnt_in) begin
          state_d = dbus_we_out ? S_DONE : S_RESP;
        end else if (interrupt_flush_in) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (dbus_rvalid_in) begin
          state_d = (discard_q | interrupt_flush_in) ? S_IDLE : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs: stall request and misalignment flag.
  always_comb begin
    stall_req_out = 1'b0;
    misalign_out  = misaligned;
    case (state_q)
      S_IDLE:  stall_req_out = start;
      S_REQ:   stall_req_out = 1'b1;
      S_RESP:  stall_req_out = 1'b1;
      default: stall_req_out = 1'b0;
    endcase
  end

  // Bus request registers, captured access attributes, discard flag and load result.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      dbus_req_out   <= 1'b0;
      dbus_we_out    <= 1'b0;
      dbus_addr_out  <= '0;
      dbus_be_out    <= '0;
      dbus_wdata_out <= '0;
      load_valid_out <= 1'b0;
      load_data_out  <= '0;
      cap_byte       <= 1'b0;
      cap_half       <= 1'b0;
      cap_signed     <= 1'b0;
      cap_a          <= 2'b00;
      discard_q      <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          discard_q <= 1'b0;
          if (start) begin
            dbus_req_out   <= 1'b1;
            dbus_we_out    <= is_store;
            dbus_addr_out  <= {mem_addr_in[ADDR_W-1:2], 2'b00};
            dbus_be_out    <= be_d;
            dbus_wdata_out <= wdata_d;
            cap_byte       <= is_byte;
            cap_half       <= is_half;
            cap_signed     <= is_signed;
            cap_a          <= a_eff;
          end
        end
        S_REQ: begin
          if (dbus_gnt_in) begin
            dbus_req_out <= 1'b0;
            // A granted load cannot be recalled; remember to drop its response.
            if (interrupt_flush_in && !dbus_we_out) discard_q <= 1'b1;
          end else if (interrupt_flush_in) begin
            dbus_req_out <= 1'b0;
          end
        end
        S_RESP: begin
          if (dbus_rvalid_in) begin
            if (!(discard_q || interrupt_flush_in)) begin
              load_data_out  <= ext_data;
              load_valid_out <= 1'b1;
            end
            discard_q <= 1'b0;
          end else if (interrupt_flush_in) begin
            discard_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu; honours MEM_LSU_MISALIGN_CHECK_EN when defined.
module tb_mem_lsu;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b0001;
  localparam logic [3:0] OP_LH   = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_LBU  = 4'b0100;
  localparam logic [3:0] OP_LHU  = 4'b0101;
  localparam logic [3:0] OP_SB   = 4'b0110;
  localparam logic [3:0] OP_SH   = 4'b0111;
  localparam logic [3:0] OP_SW   = 4'b1000;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [3:0]  mem_op_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_data_in;
  logic        mem_we_in;
  logic        interrupt_flush_in;
  logic        dbus_req_out;
  logic        dbus_we_out;
  logic [31:0] dbus_addr_out;
  logic [3:0]  dbus_be_out;
  logic [31:0] dbus_wdata_out;
  logic        dbus_gnt_in;
  logic        dbus_rvalid_in;
  logic [31:0] dbus_rdata_in;
  logic        stall_req_out;
  logic        load_valid_out;
  logic [31:0] load_data_out;
  logic        misalign_out;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .mem_op_in          (mem_op_in),
    .mem_addr_in        (mem_addr_in),
    .mem_data_in        (mem_data_in),
    .mem_we_in          (mem_we_in),
    .interrupt_flush_in (interrupt_flush_in),
    .dbus_req_out       (dbus_req_out),
    .dbus_we_out        (dbus_we_out),
    .dbus_addr_out      (dbus_addr_out),
    .dbus_be_out        (dbus_be_out),
    .dbus_wdata_out     (dbus_wdata_out),
    .dbus_gnt_in        (dbus_gnt_in),
    .dbus_rvalid_in     (dbus_rvalid_in),
    .dbus_rdata_in      (dbus_rdata_in),
    .stall_req_out      (stall_req_out),
    .load_valid_out     (load_valid_out),
    .load_data_out      (load_data_out),
    .misalign_out       (misalign_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Results recorded by do_access.
  int          r_stall, r_lv;
  logic        r_done, r_we;
  logic [31:0] r_ldata, r_addr, r_wdata;
  logic [3:0]  r_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one access as the bus slave; gnt after gnt_dly waiting REQ cycles,
  // rvalid after rv_dly waiting RESP cycles. Bounded to 40 cycles.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int gnt_dly,
                           input int rv_dly, input logic [31:0] rdata);
    int   req_n;
    int   rv_n;
    logic resp;
    logic is_st;
    is_st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    mem_op_in   = op;
    mem_addr_in = addr;
    mem_data_in = data;
    mem_we_in   = is_st;
    r_stall = 0; r_lv = 0; r_done = 1'b0;
    r_ldata = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    req_n = 0; rv_n = 0; resp = 1'b0;
    for (int i = 0; i < 40 && !r_done; i++) begin
      dbus_gnt_in    = 1'b0;
      dbus_rvalid_in = 1'b0;
      if (dbus_req_out) begin
        if (req_n == 0) begin
          r_be = dbus_be_out; r_addr = dbus_addr_out;
          r_wdata = dbus_wdata_out; r_we = dbus_we_out;
        end
        if (req_n == gnt_dly) dbus_gnt_in = 1'b1;
        req_n++;
      end
      if (resp) begin
        if (rv_n == rv_dly) begin
          dbus_rvalid_in = 1'b1;
          dbus_rdata_in  = rdata;
          resp = 1'b0;
        end
        rv_n++;
      end
      #1;
      if (stall_req_out) r_stall++;
      if (load_valid_out) begin
        r_lv++;
        r_ldata = load_data_out;
      end
      if (!stall_req_out && req_n > 0) r_done = 1'b1;
      if (dbus_gnt_in && !is_st) resp = 1'b1;
      tick();
    end
    mem_op_in      = OP_NONE;
    mem_we_in      = 1'b0;
    dbus_gnt_in    = 1'b0;
    dbus_rvalid_in = 1'b0;
    #1;
    if (load_valid_out) r_lv++;
    tick();
  endtask

  initial begin
    reset_in           = 1'b0;
    mem_op_in          = OP_NONE;
    mem_addr_in        = '0;
    mem_data_in        = '0;
    mem_we_in          = 1'b0;
    interrupt_flush_in = 1'b0;
    dbus_gnt_in        = 1'b0;
    dbus_rvalid_in     = 1'b0;
    dbus_rdata_in      = '0;

    // Reset values.
    #2;
    chk("rst_req",   32'(dbus_req_out),   32'h0);
    chk("rst_we",    32'(dbus_we_out),    32'h0);
    chk("rst_addr",  dbus_addr_out,       32'h0);
    chk("rst_be",    32'(dbus_be_out),    32'h0);
    chk("rst_wdata", dbus_wdata_out,      32'h0);
    chk("rst_lv",    32'(load_valid_out), 32'h0);
    chk("rst_ldata", load_data_out,       32'h0);
    chk("rst_stall", 32'(stall_req_out),  32'h0);
    tick();
    reset_in = 1'b1;
    tick();

    // SW, zero-wait grant.
    do_access(OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    chk("sw_done",  32'(r_done),  32'h1);
    chk("sw_stall", r_stall,      32'd2);
    chk("sw_be",    32'(r_be),    32'hF);
    chk("sw_addr",  r_addr,       32'h0000_0100);
    chk("sw_wdata", r_wdata,      32'hDEAD_BEEF);
    chk("sw_we",    32'(r_we),    32'h1);
    chk("sw_lv",    r_lv,         32'd0);

    // SB replication into lane 3.
    do_access(OP_SB, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
    chk("sb_be",    32'(r_be),    32'h8);
    chk("sb_wdata", r_wdata,      32'hA5A5_A5A5);
    chk("sb_addr",  r_addr,       32'h0000_0100);
    chk("sb_stall", r_stall,      32'd2);

    // SH replication into upper half.
    do_access(OP_SH, 32'h0000_0102, 32'h0000_1234, 0, 0, 32'h0);
    chk("sh_be",    32'(r_be),    32'hC);
    chk("sh_wdata", r_wdata,      32'h1234_1234);

    // LB sign extension from lane 1.
    do_access(OP_LB, 32'h0000_0101, 32'h0, 0, 0, 32'h0000_8000);
    chk("lb_done",  32'(r_done),  32'h1);
    chk("lb_stall", r_stall,      32'd3);
    chk("lb_lv",    r_lv,         32'd1);
    chk("lb_data",  r_ldata,      32'hFFFF_FF80);
    chk("lb_be",    32'(r_be),    32'h2);
    chk("lb_we",    32'(r_we),    32'h0);

    // LBU zero extension.
    do_access(OP_LBU, 32'h0000_0101, 32'h0, 0, 0, 32'h0000_8000);
    chk("lbu_data", r_ldata,      32'h0000_0080);

    // LHU from upper half.
    do_access(OP_LHU, 32'h0000_0102, 32'h0, 0, 0, 32'h8001_0000);
    chk("lhu_data", r_ldata,      32'h0000_8001);
    chk("lhu_be",   32'(r_be),    32'hC);

    // LH sign extension from upper half.
    do_access(OP_LH, 32'h0000_0102, 32'h0, 0, 0, 32'hBEEF_0000);
    chk("lh_data",  r_ldata,      32'hFFFF_BEEF);

    // LW with one extra gnt wait and two extra rvalid waits.
    do_access(OP_LW, 32'h0000_0104, 32'h0, 1, 2, 32'hCAFE_F00D);
    chk("lwd_done",  32'(r_done), 32'h1);
    chk("lwd_stall", r_stall,     32'd6);
    chk("lwd_lv",    r_lv,        32'd1);
    chk("lwd_data",  r_ldata,     32'hCAFE_F00D);
    chk("lwd_addr",  r_addr,      32'h0000_0104);

    // Store op without write qualifier behaves as none.
    mem_op_in = OP_SW; mem_we_in = 1'b0; mem_addr_in = 32'h0000_0200;
    #1;
    chk("nowe_stall", 32'(stall_req_out), 32'h0);
    tick();
    chk("nowe_req",   32'(dbus_req_out),  32'h0);
    mem_op_in = OP_NONE;

    // Flush in IDLE blocks a new access.
    mem_op_in = OP_SW; mem_we_in = 1'b1; interrupt_flush_in = 1'b1;
    #1;
    chk("fidle_stall", 32'(stall_req_out), 32'h0);
    tick();
    chk("fidle_req",   32'(dbus_req_out),  32'h0);
    mem_op_in = OP_NONE; mem_we_in = 1'b0; interrupt_flush_in = 1'b0;

    // Flush in REQ without grant.
    mem_op_in = OP_LW; mem_addr_in = 32'h0000_0200;
    #1;
    chk("freq_stall0", 32'(stall_req_out), 32'h1);
    tick();
    chk("freq_req1",   32'(dbus_req_out),  32'h1);
    interrupt_flush_in = 1'b1; mem_op_in = OP_NONE;
    #1;
    chk("freq_stall1", 32'(stall_req_out), 32'h1);
    tick();
    interrupt_flush_in = 1'b0;
    chk("freq_req2",   32'(dbus_req_out),  32'h0);
    chk("freq_lv2",    32'(load_valid_out), 32'h0);
    #1;
    chk("freq_stall2", 32'(stall_req_out), 32'h0);
    // Stray rvalid outside RESP is ignored.
    dbus_rvalid_in = 1'b1; dbus_rdata_in = 32'hFFFF_FFFF;
    tick();
    dbus_rvalid_in = 1'b0;
    chk("stray_lv",    32'(load_valid_out), 32'h0);
    chk("stray_ldata", load_data_out,       32'hCAFE_F00D);

    // Flush in RESP: response consumed and dropped.
    mem_op_in = OP_LW; mem_addr_in = 32'h0000_0300;
    tick();
    dbus_gnt_in = 1'b1;
    tick();
    dbus_gnt_in = 1'b0; interrupt_flush_in = 1'b1; mem_op_in = OP_NONE;
    #1;
    chk("fresp_stall0", 32'(stall_req_out), 32'h1);
    tick();
    interrupt_flush_in = 1'b0;
    dbus_rvalid_in = 1'b1; dbus_rdata_in = 32'h1122_3344;
    #1;
    chk("fresp_stall1", 32'(stall_req_out), 32'h1);
    tick();
    dbus_rvalid_in = 1'b0;
    #1;
    chk("fresp_stall2", 32'(stall_req_out),  32'h0);
    chk("fresp_lv2",    32'(load_valid_out), 32'h0);
    chk("fresp_req2",   32'(dbus_req_out),   32'h0);
    tick();
    chk("fresp_lv3",    32'(load_valid_out), 32'h0);
    chk("fresp_ldata",  load_data_out,       32'hCAFE_F00D);

    // Misaligned LW at 0x102.
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    mem_op_in = OP_LW; mem_addr_in = 32'h0000_0102;
    #1;
    chk("mis_flag",  32'(misalign_out),  32'h1);
    chk("mis_stall", 32'(stall_req_out), 32'h0);
    tick();
    chk("mis_req",   32'(dbus_req_out),  32'h0);
    mem_op_in = OP_NONE;
    #1;
    chk("mis_clear", 32'(misalign_out),  32'h0);
    tick();
`else
    mem_op_in = OP_LW; mem_addr_in = 32'h0000_0102;
    #1;
    chk("mis_flag",  32'(misalign_out),  32'h0);
    do_access(OP_LW, 32'h0000_0102, 32'h0, 0, 0, 32'h5566_7788);
    chk("mis_addr",  r_addr,      32'h0000_0100);
    chk("mis_be",    32'(r_be),   32'hF);
    chk("mis_data",  r_ldata,     32'h5566_7788);
`endif

    // Reset asserted mid-access returns to IDLE immediately.
    mem_op_in = OP_LW; mem_addr_in = 32'h0000_0400;
    tick();
    chk("mrst_req1",  32'(dbus_req_out),  32'h1);
    reset_in = 1'b0; mem_op_in = OP_NONE;
    #1;
    chk("mrst_req0",  32'(dbus_req_out),  32'h0);
    chk("mrst_stall", 32'(stall_req_out), 32'h0);
    tick();
    reset_in = 1'b1;
    tick();
    chk("mrst_lv",    32'(load_valid_out), 32'h0);
    chk("mrst_ldata", load_data_out,       32'h0);
    chk("mrst_req2",  32'(dbus_req_out),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

- MEM-stage load/store unit that receives the registered memory-access fields from the EX/MEM pipeline register: `mem_op`, `mem_addr`, `mem_data` and `mem_we`.
- Drives a single-outstanding request/grant/response data bus and stalls the pipeline until each access completes.
- Handles byte-lane steering, store data replication and load sign/zero extension.
- Sits between the EX/MEM register and the MEM/WB register. The stall request goes to pipe_ctrl.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: bus and register data width (fixed to 32 by the byte-lane logic).
- `clk_in`, input, 1: the single clock.
- `reset_in`, input, 1: asynchronous, active-low reset.
- `mem_op_in`, input, 4: access type.
  - Encodings: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 0110 SB, 0111 SH, 1000 SW.
  - Other values behave as none.
- `mem_addr_in`, input, ADDR_W: byte address.
- `mem_data_in`, input, DATA_W: store data (rs2).
- `mem_we_in`, input, 1: store qualifier. An access is a store only if both the op and this bit say store.
- `interrupt_flush_in`, input, 1: flush from pipe_ctrl.
- `dbus_req_out`, output, 1: request valid.
- `dbus_we_out`, output, 1: write.
- `dbus_addr_out`, output, ADDR_W: word-aligned address (bits [1:0] = 00).
- `dbus_be_out`, output, 4: byte enables.
- `dbus_wdata_out`, output, DATA_W: lane-replicated write data.
- `dbus_gnt_in`, input, 1: request accepted.
- `dbus_rvalid_in`, input, 1: read data valid.
- `dbus_rdata_in`, input, DATA_W: read data.
- `stall_req_out`, output, 1: hold the pipeline.
- `load_valid_out`, output, 1: `load_data_out` is valid this cycle.
- `load_data_out`, output, DATA_W: extended load result.
- `misalign_out`, output, 1: misaligned access detected.

## Operation
- States: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- Reset values: all `dbus_*` outputs are 0, `load_data_out` is 0, `load_valid_out` is 0.
- Transitions:
  - IDLE, valid op, not misaligned, no flush: capture the access into the dbus registers and go to REQ.
  - REQ: `dbus_req_out` is high.
    - On `dbus_gnt_in`, a store goes to DONE and a load goes to RESP.
    - On flush without grant, drop the request and go to IDLE.
  - RESP:
    - On `dbus_rvalid_in`, register the extended data and go to DONE.
    - A flush seen in REQ (with grant) or in RESP sets a discard flag. The unit still waits for `rvalid`, then goes to IDLE without asserting `load_valid_out`.
  - DONE: `load_valid_out` is 1 for loads. Go to IDLE next cycle.
- Byte lanes use `a = mem_addr_in[1:0]`:
  - SB/LB/LBU: `be = 0001 << a`.
  - SH/LH/LHU: `be = 0011 << a`.
  - SW/LW: `be = 1111`.
- Write data:
  - SB replicates byte [7:0] to all four lanes.
  - SH replicates half [15:0] to both halves.
  - SW passes data through.
- Load extract: select lane byte/half by the captured `a`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- `stall_req_out` is combinational. It is 1 when (IDLE and valid op and not misaligned and no flush) or REQ or RESP. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Flush in IDLE or DONE: no new access is issued.

## Timing
- Store, zero-wait grant: cycle 0 IDLE (stall=1), cycle 1 REQ+gnt, cycle 2 DONE (stall=0). Total 3 cycles.
- Load, gnt at cycle 1, rvalid at cycle 2: DONE at cycle 3 with data. Total 4 cycles.
- Each extra cycle of `gnt` or `rvalid` latency adds one stall cycle.
- `dbus_addr`/`be`/`wdata`/`we` are stable from REQ entry until grant.
- `dbus_rvalid_in` outside RESP is ignored.
- Reset asserted mid-access forces IDLE immediately. The bus slave must also be reset.

## Configuration
- `MEM_LSU_MISALIGN_CHECK_EN` defined:
  - A halfword access with `a = 11`, or a word access with `a != 00`, sets `misalign_out` = 1 combinationally.
  - No bus access and no stall result.
- Not defined:
  - `misalign_out` is tied 0.
  - The address is truncated to natural alignment: half uses `a & 10`, word uses `a = 00`.
  - The access proceeds normally.

## Test plan
- SW to addr 0x100, data 0xDEADBEEF, gnt immediate:
  - Required: req with be=1111, addr=0x100, wdata=0xDEADBEEF.
  - Stall high 2 cycles; DONE at cycle 2.
- SB to 0x103, data 0x000000A5:
  - Required: be=1000, wdata=0xA5A5A5A5.
  - SH to 0x102, data 0x1234: be=1100, wdata=0x12341234.
- LB from 0x101 with rdata 0x00008000:
  - Required: `load_data_out` = 0xFFFFFF80.
  - LBU from the same: 0x00000080.
  - LHU from 0x102 with rdata 0x80010000: 0x00008001.
- LW with gnt delayed 2 cycles and rvalid delayed 3 cycles:
  - Required: stall held 6 cycles.
  - `load_valid_out` pulses exactly once.
- Flush cases:
  - Flush while in REQ without gnt: req drops next cycle, state IDLE, no `load_valid_out`.
  - Flush in RESP: rvalid consumed, data discarded.
- LW at 0x102 with `MEM_LSU_MISALIGN_CHECK_EN`:
  - Required: `misalign_out`=1, no req, stall=0.
  - Without the macro: req addr 0x100, be=1111.
